spi_agc_axil_slave: RTL and testbench
=====================================

Name: spi_agc_axil_slave

Overview:
AXI4-Lite slave register bank that responds to the PS-side AXI4-Lite master and holds the SPI AGC configuration words. It provides four fully read/write 32-bit registers, applies byte strobes, and emits a one-cycle update pulse per register. The SPI AGC engine consumes these pulses to launch gain-word transfers. It sits between the AXI interconnect and the SPI AGC core inside the SPI_AGC IP.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, AXI address width; bits [3:2] select the register and bits [1:0] are ignored.

Ports:
S_AXI_ACLK  in  1  single clock for the whole block
S_AXI_ARESETN  in  1  asynchronous, active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response; always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response; always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
agc_reg0  out  32  register 0 contents (offset 0x0)
agc_reg1  out  32  register 1 contents (offset 0x4)
agc_reg2  out  32  register 2 contents (offset 0x8)
agc_reg3  out  32  register 3 contents (offset 0xC)
agc_reg_upd  out  4  one-cycle pulse; bit i is set on a committed write to register i

Behaviour:
- Reset (async assert, release synchronised by the caller): all outputs are 0, including every register, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA and agc_reg_upd. The internal aw_held and w_held flags are cleared.
- Reset asserted mid-transaction aborts everything. No partial write lands. Any in-flight BVALID or RVALID drops immediately.
- Write address channel:
  - AWREADY = !aw_held, registered.
  - An AW handshake latches address bits [3:2] and sets aw_held.
- Write data channel:
  - WREADY = !w_held, registered.
  - A W handshake latches WDATA and WSTRB and sets w_held.
- AW and W may arrive in either order or in the same cycle. Each channel is accepted independently; a second AW is never accepted before the first write commits.
- Commit condition: aw_held && w_held && !BVALID. On the commit edge:
  - The selected register updates byte-wise, byte k written only when WSTRB[k]=1.
  - BVALID is set.
  - The selected agc_reg_upd bit is high for exactly the following cycle.
  - Both held flags clear.
- Commit with WSTRB=0 still produces a response and an upd pulse; register contents are unchanged.
- Write latency: AW and W handshaked on edge N gives commit and BVALID=1 after edge N+1.
- BVALID holds until BREADY; it clears on the BVALID&&BREADY edge. New AW/W may be accepted while BVALID is pending, but commit waits for it to clear.
- Read channel:
  - ARREADY = !RVALID && !ar_busy.
  - On an AR handshake at edge N, RDATA is loaded from the register selected by ARADDR[3:2], with RVALID=1 after edge N.
  - RDATA and RVALID hold stable until RVALID&&RREADY; RVALID then clears and ARREADY returns the next cycle.
  - Maximum read throughput is one read per two cycles.
- Read/write collision: if an AR handshake and a write commit to the same register occur on the same edge, RDATA returns the pre-write value. A later read returns the new value.
- Out-of-range addresses cannot occur (2-bit decode wraps: 0x10 aliases 0x0). RRESP and BRESP are always OKAY.
- agc_regN outputs are the live register values; no extra delay.

Test Plan:
- Sequential write/read at 0x0, 0x4, 0x8, 0xC with 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011, WSTRB=0xF -> each BRESP=00, each readback equals the written data, agc_reg_upd pulses bits 0, 1, 2, 3 in turn, one cycle each.
- W presented 3 cycles before AW (0x4, 0x12345678) -> WREADY drops after the W handshake, no commit until AW arrives, then BVALID=1 one cycle after the AW handshake; agc_reg1=0x12345678.
- BREADY held low for 5 cycles followed by a second AW/W to 0x8 -> second write accepted but not committed, BVALID stays 1, agc_reg2 unchanged until the first B handshake; then commit, and a second BVALID follows.
- Partial strobe: reg0=0x0101FFFF, then write 0xAABBCCDD with WSTRB=0x5 -> reg0 reads 0x01BBFFDD.
- Same-edge AR and commit on 0xC (old 0xBEEF0011, new 0x00000022) -> RDATA=0xBEEF0011; a follow-up read returns 0x00000022.
- Assert ARESETN low while RVALID=1 and aw_held=1 -> RVALID, BVALID and all agc_regN drop to 0 asynchronously; after release, a read of 0x0 returns 0x00000000.

Source files
------------

// File: rtl/spi_agc_axil_slave.sv
// AXI4-Lite register bank holding four SPI AGC configuration words.
// Each committed write raises a one-cycle update pulse for the register written.
module spi_agc_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     agc_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     agc_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     agc_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     agc_reg3,
    output logic [3:0]                        agc_reg_upd
);
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic                          r_arready;
    logic                          r_rvalid;
    logic                          r_aw_held;
    logic                          r_w_held;
    logic [1:0]                    r_aw_sel;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]                 r_wstrb;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];
    logic [3:0]                    r_upd;

    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_b_hs;
    logic                          w_ar_hs;
    logic                          w_r_hs;
    logic                          w_commit;
    logic                          w_aw_held_next;
    logic                          w_w_held_next;
    logic                          w_rvalid_next;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_word;
    logic                          w_unused_ok;

    assign w_aw_hs  = S_AXI_AWVALID && r_awready;
    assign w_w_hs   = S_AXI_WVALID && r_wready;
    assign w_b_hs   = r_bvalid && S_AXI_BREADY;
    assign w_ar_hs  = S_AXI_ARVALID && r_arready;
    assign w_r_hs   = r_rvalid && S_AXI_RREADY;
    // A pending response blocks the commit, so at most one B is ever outstanding.
    assign w_commit = r_aw_held && r_w_held && !r_bvalid;

    assign w_aw_held_next = w_commit ? 1'b0 : (r_aw_held || w_aw_hs);
    assign w_w_held_next  = w_commit ? 1'b0 : (r_w_held || w_w_hs);
    assign w_rvalid_next  = w_ar_hs || (r_rvalid && !w_r_hs);

    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign w_wr_word[gi*8 +: 8] = r_wstrb[gi] ? r_wdata[gi*8 +: 8]
                                                  : r_regs[r_aw_sel][gi*8 +: 8];
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_sel  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_upd     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_aw_held <= w_aw_held_next;
            r_w_held  <= w_w_held_next;
            r_awready <= !w_aw_held_next;
            r_wready  <= !w_w_held_next;
            r_rvalid  <= w_rvalid_next;
            r_arready <= !w_rvalid_next;

            if (w_aw_hs) begin
                r_aw_sel <= S_AXI_AWADDR[3:2];
            end
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
            end else if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end

            r_upd <= '0;
            if (w_commit) begin
                r_upd[r_aw_sel] <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (w_commit && (r_aw_sel == 2'(i))) begin
                    r_regs[i] <= w_wr_word;
                end
            end

            // Sampled before this edge's commit lands, so a colliding read sees the old word.
            if (w_ar_hs) begin
                r_rdata <= r_regs[S_AXI_ARADDR[3:2]];
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = r_rvalid;
    assign agc_reg0      = r_regs[0];
    assign agc_reg1      = r_regs[1];
    assign agc_reg2      = r_regs[2];
    assign agc_reg3      = r_regs[3];
    assign agc_reg_upd   = r_upd;

    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_spi_agc_axil_slave.sv
// Self-checking bench for spi_agc_axil_slave: a register model plus a read-data
// scoreboard queue filled when AR is driven and drained when R is returned.
`timescale 1ns/1ps
module tb_spi_agc_axil_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [3:0]  araddr = '0;
    logic [2:0]  awprot = '0;
    logic [2:0]  arprot = '0;
    logic        awvalid = 1'b0;
    logic        wvalid = 1'b0;
    logic        bready = 1'b0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [31:0] agc_reg0, agc_reg1, agc_reg2, agc_reg3;
    logic [3:0]  upd;
    logic [31:0] agc_w [4];

    logic [31:0] mdl [4];
    logic [31:0] rd_exp_q [$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    spi_agc_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .agc_reg0     (agc_reg0),
        .agc_reg1     (agc_reg1),
        .agc_reg2     (agc_reg2),
        .agc_reg3     (agc_reg3),
        .agc_reg_upd  (upd)
    );

    assign agc_w[0] = agc_reg0;
    assign agc_w[1] = agc_reg1;
    assign agc_w[2] = agc_reg2;
    assign agc_w[3] = agc_reg3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) r[k*8 +: 8] = d[k*8 +: 8];
        end
        return r;
    endfunction

    task automatic b_handshake(input string tag);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check({tag, "_upd_clear"}, 32'(upd), 32'h0);
        check({tag, "_bvalid_clear"}, 32'(bvalid), 32'h0);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int         n;
        logic [1:0] sel;
        logic       aw_hs, w_hs;
        sel = addr[3:2];
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            n++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
        end
        if (awvalid || wvalid) begin
            check("wr_accept_timeout", 32'(awvalid | wvalid), 32'h0);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        n = 0;
        while (!bvalid && n < 20) begin
            step();
            n++;
        end
        mdl[sel] = merge(mdl[sel], data, strb);
        check("wr_bvalid", 32'(bvalid), 32'h1);
        check("wr_bresp", 32'(bresp), 32'h0);
        check("wr_upd", 32'(upd), 32'h1 << sel);
        check("wr_reg", agc_w[sel], mdl[sel]);
        $display("WR addr=0x%h data=0x%08h strb=0x%h reg=0x%08h", addr, data, strb, agc_w[sel]);
        b_handshake("wr");
    endtask

    task automatic recv_read(input string tag);
        logic [31:0] exp;
        check({tag, "_rvalid"}, 32'(rvalid), 32'h1);
        if (rd_exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(rd_exp_q.size()), 32'h1);
        end else begin
            exp = rd_exp_q.pop_front();
            check({tag, "_rdata"}, rdata, exp);
        end
        check({tag, "_rresp"}, 32'(rresp), 32'h0);
        $display("RD data=0x%08h", rdata);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check({tag, "_rvalid_clear"}, 32'(rvalid), 32'h0);
    endtask

    task automatic axi_read(input logic [3:0] addr);
        int n;
        araddr = addr; arvalid = 1'b1;
        rd_exp_q.push_back(mdl[addr[3:2]]);
        n = 0;
        while (!arready && n < 20) begin
            step();
            n++;
        end
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            step();
            n++;
        end
        recv_read("rd");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mdl[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'h0);
        check("rst_wready", 32'(wready), 32'h0);
        check("rst_bvalid", 32'(bvalid), 32'h0);
        check("rst_arready", 32'(arready), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_upd", 32'(upd), 32'h0);
        for (int i = 0; i < 4; i++) check("rst_reg", agc_w[i], 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_awready", 32'(awready), 32'h1);
        check("idle_wready", 32'(wready), 32'h1);
        check("idle_arready", 32'(arready), 32'h1);

        // Sequential write/read of all four registers
        axi_write(4'h0, 32'h0101FFFF, 4'hF);
        axi_read(4'h0);
        axi_write(4'h4, 32'hABCD0001, 4'hF);
        axi_read(4'h4);
        axi_write(4'h8, 32'hDEAD0011, 4'hF);
        axi_read(4'h8);
        axi_write(4'hC, 32'hBEEF0011, 4'hF);
        axi_read(4'hC);

        // W ahead of AW by three cycles
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("wfirst_wready_drop", 32'(wready), 32'h0);
        step();
        step();
        check("wfirst_no_commit", 32'(bvalid), 32'h0);
        check("wfirst_reg1_hold", agc_reg1, mdl[1]);
        awaddr = 4'h4; awvalid = 1'b1;
        check("wfirst_awready", 32'(awready), 32'h1);
        step();
        awvalid = 1'b0;
        check("wfirst_bvalid_n", 32'(bvalid), 32'h0);
        step();
        mdl[1] = 32'h12345678;
        check("wfirst_bvalid_n1", 32'(bvalid), 32'h1);
        check("wfirst_upd", 32'(upd), 32'h2);
        check("wfirst_reg1", agc_reg1, 32'h12345678);
        $display("WR addr=0x4 data=0x%08h (W before AW)", agc_reg1);
        b_handshake("wfirst");

        // BREADY held low while a second write queues up behind the first
        awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h0101FFFF; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        mdl[0] = 32'h0101FFFF;
        check("bp_first_bvalid", 32'(bvalid), 32'h1);
        repeat (5) step();
        awaddr = 4'h8; awvalid = 1'b1; wdata = 32'h5A5A5A5A; wvalid = 1'b1;
        check("bp_awready", 32'(awready), 32'h1);
        check("bp_wready", 32'(wready), 32'h1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        step();
        check("bp_bvalid_hold", 32'(bvalid), 32'h1);
        check("bp_reg2_hold", agc_reg2, mdl[2]);
        check("bp_no_upd", 32'(upd), 32'h0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bp_bvalid_gap", 32'(bvalid), 32'h0);
        check("bp_reg2_still", agc_reg2, mdl[2]);
        step();
        mdl[2] = 32'h5A5A5A5A;
        check("bp_second_bvalid", 32'(bvalid), 32'h1);
        check("bp_second_upd", 32'(upd), 32'h4);
        check("bp_reg2_new", agc_reg2, mdl[2]);
        $display("WR addr=0x8 data=0x%08h (behind held B)", agc_reg2);
        b_handshake("bp");
        axi_read(4'h8);

        // Partial strobe
        axi_write(4'h0, 32'hAABBCCDD, 4'h5);
        check("strb_reg0", agc_reg0, 32'h01BBFFDD);
        axi_read(4'h0);

        // AR and commit on the same edge to 0xC
        awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h00000022; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 4'hC; arvalid = 1'b1;
        check("coll_arready", 32'(arready), 32'h1);
        rd_exp_q.push_back(mdl[3]);
        step();
        arvalid = 1'b0;
        mdl[3] = 32'h00000022;
        check("coll_bvalid", 32'(bvalid), 32'h1);
        check("coll_reg3", agc_reg3, 32'h00000022);
        recv_read("coll");
        bready = 1'b1;
        step();
        bready = 1'b0;
        axi_read(4'hC);

        // Reset during an open read and a held AW
        araddr = 4'h0; arvalid = 1'b1; awaddr = 4'h4; awvalid = 1'b1;
        step();
        arvalid = 1'b0; awvalid = 1'b0;
        check("mid_rvalid", 32'(rvalid), 32'h1);
        check("mid_aw_held", 32'(awready), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rvalid", 32'(rvalid), 32'h0);
        check("arst_bvalid", 32'(bvalid), 32'h0);
        check("arst_upd", 32'(upd), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("arst_reg", agc_w[i], 32'h0);
            mdl[i] = '0;
        end
        $display("RESET asserted mid-transaction");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        step();
        step();
        check("arst_aw_cleared", 32'(bvalid), 32'h0);
        awaddr = 4'h8; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        step();
        mdl[2] = 32'h00000077;
        check("arst_after_bvalid", 32'(bvalid), 32'h1);
        check("arst_after_reg2", agc_reg2, mdl[2]);
        b_handshake("arst");
        axi_read(4'h0);
        axi_read(4'h8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
